// File: rtl/parity_serializer.sv
// parity_serializer
//   Accepts a WIDTH-bit word over a valid/ready handshake, shifts it out one
//   bit per clock (LSB or MSB first), then appends a single parity bit whose
//   sense (even/odd) is chosen per word. Completed frames are counted.
//
// Parameters
//   WIDTH      data bits per frame (1..64)
//   MSB_FIRST  0 = LSB first, 1 = MSB first
//   CNT_W      width of the completed-frame counter
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       source presents a word
//   in_ready       block can accept a word this cycle
//   in_data        word to serialise, sampled on accept
//   odd_mode       1 = odd parity, 0 = even parity, sampled on accept
//   ser_out        serial data/parity bit
//   ser_valid      ser_out carries a frame bit
//   ser_is_parity  ser_out is the parity bit (last bit of the frame)
//   ser_first      ser_out is the first data bit of a frame
//   parity_last    parity bit of the most recently accepted word
//   frame_cnt      completed frames, wraps modulo 2^CNT_W
//
// States
//   IDLE   | no frame in flight
//   DATA   | sending data bit index 0..WIDTH-1
//   PARITY | sending the parity bit; may accept the next word
module parity_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             odd_mode,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_is_parity,
  output logic             ser_first,
  output logic             parity_last,
  output logic [CNT_W-1:0] frame_cnt
);

  // A 1-bit index is kept even for WIDTH=1 so the index logic stays uniform.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             new_parity;

  assign in_ready   = (state == IDLE) || (state == PARITY);
  assign accept     = in_valid && in_ready;
  assign new_parity = (^in_data) ^ odd_mode;

  // Bit that goes on the wire next, taken from the leading end of the word.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its leading bit consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // ser_out is registered: the bit presented in a DATA cycle is loaded at the
  // preceding edge, so the shift register always holds the bits still to go.
  // parity_last doubles as the in-flight parity; a back-to-back accept only
  // overwrites it at the edge that ends the parity cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      shreg         <= '0;
      ser_out       <= 1'b0;
      ser_valid     <= 1'b0;
      ser_is_parity <= 1'b0;
      ser_first     <= 1'b0;
      parity_last   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (state == PARITY) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end

      if (accept) begin
        state         <= DATA;
        idx           <= '0;
        shreg         <= advance(in_data);
        parity_last   <= new_parity;
        ser_out       <= lead_bit(in_data);
        ser_valid     <= 1'b1;
        ser_first     <= 1'b1;
        ser_is_parity <= 1'b0;
      end else begin
        case (state)
          DATA: begin
            ser_first <= 1'b0;
            if (idx == LAST_IDX) begin
              state         <= PARITY;
              ser_out       <= parity_last;
              ser_is_parity <= 1'b1;
            end else begin
              idx     <= idx + IDX_W'(1);
              ser_out <= lead_bit(shreg);
              shreg   <= advance(shreg);
            end
          end
          default: begin
            // PARITY without a follow-on word, or IDLE: line goes quiet.
            state         <= IDLE;
            ser_out       <= 1'b0;
            ser_valid     <= 1'b0;
            ser_is_parity <= 1'b0;
            ser_first     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
